// File: rtl/onehot_regfile_pkg.sv
// rtl/onehot_regfile_pkg.sv - shared widths, data type and one-hot helpers for the register file
package onehot_regfile_pkg;

    localparam int ENCODE_WIDTH = 2;
    localparam int DECODE_WIDTH = 2 ** ENCODE_WIDTH;
    localparam int DATA_WIDTH   = 8;
    localparam int CNT_WIDTH    = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;

    function automatic logic is_onehot(input logic [DECODE_WIDTH-1:0] sel);
        return ($countones(sel) == 1);
    endfunction

    function automatic logic [ENCODE_WIDTH-1:0] onehot_to_idx(input logic [DECODE_WIDTH-1:0] sel);
        logic [ENCODE_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (sel[i]) begin
                idx = idx | ENCODE_WIDTH'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_regfile_if.sv
// rtl/onehot_regfile_if.sv - write/read/status bundle between requester and register file
interface onehot_regfile_if
    import onehot_regfile_pkg::*;
#(
    parameter int P_ENCODE_WIDTH = ENCODE_WIDTH,
    parameter int P_DECODE_WIDTH = DECODE_WIDTH,
    parameter int P_DATA_WIDTH   = DATA_WIDTH,
    parameter int P_CNT_WIDTH    = CNT_WIDTH
);
    logic                      wr_en;
    logic [P_DECODE_WIDTH-1:0] wr_sel;
    logic [P_DATA_WIDTH-1:0]   wr_data;
    logic [P_ENCODE_WIDTH-1:0] rd_addr_a;
    logic [P_ENCODE_WIDTH-1:0] rd_addr_b;
    logic [P_DATA_WIDTH-1:0]   rd_data_a;
    logic [P_DATA_WIDTH-1:0]   rd_data_b;
    logic                      err_clr;
    logic                      err_sel;
    logic [P_CNT_WIDTH-1:0]    wr_count;

    modport master (
        output wr_en, wr_sel, wr_data, rd_addr_a, rd_addr_b, err_clr,
        input  rd_data_a, rd_data_b, err_sel, wr_count
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rd_addr_a, rd_addr_b, err_clr,
        output rd_data_a, rd_data_b, err_sel, wr_count
    );
endinterface

// File: rtl/onehot_regfile_check.sv
// rtl/onehot_regfile_check.sv - combinational one-hot validity flag and encoded index
module onehot_regfile_check #(
    parameter int W  = 4,
    parameter int EW = 2
) (
    input  logic [W-1:0]  i_sel,
    output logic          o_valid,
    output logic [EW-1:0] o_idx
);
    logic [W-1:0] w_sel_m1;

    assign w_sel_m1 = i_sel - W'(1);
    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign o_valid  = (i_sel != '0) && ((i_sel & w_sel_m1) == '0);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (i_sel[i]) begin
                o_idx = o_idx | EW'(i);
            end
        end
    end
endmodule

// File: rtl/onehot_regfile.sv
// rtl/onehot_regfile.sv - one-hot addressed register file with two forwarding registered read ports
module onehot_regfile
    import onehot_regfile_pkg::*;
#(
    parameter int P_ENCODE_WIDTH = ENCODE_WIDTH,
    parameter int P_DECODE_WIDTH = 2 ** P_ENCODE_WIDTH,
    parameter int P_DATA_WIDTH   = DATA_WIDTH,
    parameter int P_CNT_WIDTH    = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    onehot_regfile_if.slave  bus
);
    logic [P_DATA_WIDTH-1:0]   r_regs [P_DECODE_WIDTH];
    logic [P_DATA_WIDTH-1:0]   r_rd_data_a;
    logic [P_DATA_WIDTH-1:0]   r_rd_data_b;
    logic                      r_err_sel;
    logic [P_CNT_WIDTH-1:0]    r_wr_count;

    logic                      w_sel_valid;
    logic [P_ENCODE_WIDTH-1:0] w_sel_idx;
    logic                      w_commit;
    logic                      w_bad_sel;
    logic                      w_fwd_a;
    logic                      w_fwd_b;

    onehot_regfile_check #(
        .W  (P_DECODE_WIDTH),
        .EW (P_ENCODE_WIDTH)
    ) u_check (
        .i_sel   (bus.wr_sel),
        .o_valid (w_sel_valid),
        .o_idx   (w_sel_idx)
    );

    assign w_commit  = bus.wr_en && w_sel_valid;
    assign w_bad_sel = bus.wr_en && !w_sel_valid;
    assign w_fwd_a   = w_commit && (w_sel_idx == bus.rd_addr_a);
    assign w_fwd_b   = w_commit && (w_sel_idx == bus.rd_addr_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_DECODE_WIDTH; i++) begin
                r_regs[i] <= '0;
            end
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
            r_err_sel   <= 1'b0;
            r_wr_count  <= '0;
        end else begin
            if (w_commit) begin
                r_regs[w_sel_idx] <= bus.wr_data;
                r_wr_count        <= r_wr_count + P_CNT_WIDTH'(1);
            end
            // A malformed select in the same cycle as a clear keeps the flag raised.
            if (w_bad_sel) begin
                r_err_sel <= 1'b1;
            end else if (bus.err_clr) begin
                r_err_sel <= 1'b0;
            end
            r_rd_data_a <= w_fwd_a ? bus.wr_data : r_regs[bus.rd_addr_a];
            r_rd_data_b <= w_fwd_b ? bus.wr_data : r_regs[bus.rd_addr_b];
        end
    end

    assign bus.rd_data_a = r_rd_data_a;
    assign bus.rd_data_b = r_rd_data_b;
    assign bus.err_sel   = r_err_sel;
    assign bus.wr_count  = r_wr_count;
endmodule
